// File: rtl/rv32_data_mem_controller.sv
//==============================================================================
// Module      : rv32_data_mem_controller
// Description : Data-memory front end for the multicycle RV32I core. Decodes
//               the bank, checks alignment, extracts and extends load lanes and
//               performs byte/half stores as read-modify-write on a RAM that
//               has no byte enables.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32_dmem_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [1:0] mem_exception_mask_t;

    localparam mem_exception_mask_t MEM_EXCEPT_MISALIGNED    = 2'b01;
    localparam mem_exception_mask_t MEM_EXCEPT_ILLEGAL_ADDR  = 2'b10;
endpackage

module rv32_data_mem_controller
    import rv32_dmem_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [3:0] BANK   = 4'h1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic [31:0]         core_addr,
    input  logic                core_wr_ena,
    input  logic [31:0]         core_wr_data,
    input  mem_access_t         core_access,
    input  logic                core_unsigned,
    output logic                core_busy,
    output logic                core_done,
    output logic [31:0]         core_rd_data,
    output mem_exception_mask_t core_exception,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [31:0]         ram_rd_data,
    output logic [31:0]         ram_wr_data,
    output logic                ram_wr_ena
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Latched request; only the address bits that reach the RAM or select a
    // lane are kept, and only the low half of the store data is ever needed
    // after acceptance (full-word stores complete in the accept cycle).
    logic [ADDR_W+1:0]   r_addr;
    logic                r_wr_ena;
    logic [15:0]         r_wr_data;
    mem_access_t         r_access;
    logic                r_unsigned;
    mem_exception_mask_t r_exc;

    mem_exception_mask_t w_exc;
    logic                w_word_store;
    logic [31:0]         w_shift;
    logic [31:0]         w_load;
    logic [31:0]         w_merged;

    // Exception decode on the live request, used at acceptance
    always_comb begin
        w_exc = '0;
        if ((core_addr[31:28] != BANK) || (|core_addr[27:ADDR_W+2]))
            w_exc = w_exc | MEM_EXCEPT_ILLEGAL_ADDR;
        if (((core_access == MEM_ACCESS_HALF) && core_addr[0]) ||
            ((core_access == MEM_ACCESS_WORD) && (core_addr[1:0] != 2'b00)))
            w_exc = w_exc | MEM_EXCEPT_MISALIGNED;
    end

    assign w_word_store = core_wr_ena && (core_access == MEM_ACCESS_WORD);

    // Load lane extraction with sign or zero extension from the latched request
    always_comb begin
        w_shift = ram_rd_data >> {r_addr[1:0], 3'b000};
        case (r_access)
            MEM_ACCESS_BYTE: w_load = {{24{~r_unsigned & w_shift[7]}},  w_shift[7:0]};
            MEM_ACCESS_HALF: w_load = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
            default:         w_load = ram_rd_data;
        endcase
    end

    // Store merge: overwrite the addressed byte or half of the word just read
    always_comb begin
        w_merged = ram_rd_data;
        case (r_access)
            MEM_ACCESS_BYTE: begin
                case (r_addr[1:0])
                    2'd0:    w_merged[7:0]   = r_wr_data[7:0];
                    2'd1:    w_merged[15:8]  = r_wr_data[7:0];
                    2'd2:    w_merged[23:16] = r_wr_data[7:0];
                    default: w_merged[31:24] = r_wr_data[7:0];
                endcase
            end
            MEM_ACCESS_HALF: begin
                if (r_addr[1])
                    w_merged[31:16] = r_wr_data;
                else
                    w_merged[15:0]  = r_wr_data;
            end
            default: w_merged = ram_rd_data;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state decode; exceptions and full-word stores skip the read cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (core_req) begin
                    if ((w_exc != '0) || w_word_store)
                        w_next_state = S_DONE;
                    else
                        w_next_state = S_READ;
                end
            end
            S_READ:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode; RAM address follows the live request while idle
    always_comb begin
        core_busy      = (r_state != S_IDLE);
        core_done      = 1'b0;
        core_exception = '0;
        ram_addr       = r_addr[ADDR_W+1:2];
        ram_wr_ena     = 1'b0;
        ram_wr_data    = '0;
        case (r_state)
            S_IDLE: begin
                ram_addr = core_addr[ADDR_W+1:2];
                if (core_req && w_word_store && (w_exc == '0)) begin
                    ram_wr_ena  = 1'b1;
                    ram_wr_data = core_wr_data;
                end
            end
            S_READ: begin
                if (r_wr_ena) begin
                    ram_wr_ena  = 1'b1;
                    ram_wr_data = w_merged;
                end
            end
            S_DONE: begin
                core_done      = 1'b1;
                core_exception = r_exc;
            end
            default: ;
        endcase
    end

    // Request latch at acceptance and load-result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wr_ena     <= 1'b0;
            r_wr_data    <= '0;
            r_access     <= MEM_ACCESS_BYTE;
            r_unsigned   <= 1'b0;
            r_exc        <= '0;
            core_rd_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && core_req) begin
                r_addr     <= core_addr[ADDR_W+1:0];
                r_wr_ena   <= core_wr_ena;
                r_wr_data  <= core_wr_data[15:0];
                r_access   <= core_access;
                r_unsigned <= core_unsigned;
                r_exc      <= w_exc;
            end
            if ((r_state == S_READ) && !r_wr_ena)
                core_rd_data <= w_load;
        end
    end

endmodule

`default_nettype wire
